// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage owning the PC, the IF/ID register and a saturating fetch counter.
// Priority per edge: redirect > flush(+stall) > stall > normal fetch.
module if_stage #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [PC_WIDTH-1:0] if_id_pc_plus4,
    output logic                if_id_valid,
    output logic [31:0]         fetch_count,
    output logic                misalign_err
);
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;

    assign pc_plus4  = pc + PC_WIDTH'(4);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
            misalign_err   <= 1'b0;
        end else if (branch_taken) begin
            // bubble keeps the previous PC fields; the target is forced word-aligned
            pc           <= {branch_target[PC_WIDTH-1:2], 2'b00};
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            misalign_err <= misalign_err | (branch_target[1:0] != 2'b00);
        end else if (flush) begin
            if (!stall) pc <= pc_plus4;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= imem_rdata;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            if (fetch_count != '1) fetch_count <= fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: random and directed stimulus against a per-edge behavioural model of the fetch stage.
module tb_if_stage;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count), .misalign_err(misalign_err)
    );

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] cnt;
        logic        valid;
        logic        mis;
    } st_t;

    st_t m;

    function automatic st_t reset_st();
        st_t r;
        r = '0;
        return r;
    endfunction

    // One clock edge of the fetch stage, applied by priority
    function automatic st_t step(st_t s, logic b, logic f, logic st, logic [31:0] t);
        st_t n;
        n = s;
        if (b) begin
            n.pc    = t & 32'hFFFF_FFFC;
            n.instr = 32'h0;
            n.valid = 1'b0;
            n.mis   = s.mis || (t % 4 != 0);
        end else if (f) begin
            if (!st) n.pc = s.pc + 32'd4;
            n.instr = 32'h0;
            n.valid = 1'b0;
        end else if (!st) begin
            n.pc    = s.pc + 32'd4;
            n.instr = s.pc ^ 32'hA5A5_0000;
            n.ipc   = s.pc;
            n.ipc4  = s.pc + 32'd4;
            n.valid = 1'b1;
            n.cnt   = (s.cnt == 32'hFFFF_FFFF) ? s.cnt : s.cnt + 32'd1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= reset_st();
        else m <= step(m, branch_taken, flush, stall, branch_target);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_addr", imem_addr, m.pc);
            check("if_id_instr", if_id_instr, m.instr);
            check("if_id_pc", if_id_pc, m.ipc);
            check("if_id_pc_plus4", if_id_pc_plus4, m.ipc4);
            check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m.valid});
            check("fetch_count", fetch_count, m.cnt);
            check("misalign_err", {31'b0, misalign_err}, {31'b0, m.mis});
        end
    end

    task automatic cyc(input logic b, input logic f, input logic s, input logic [31:0] t);
        branch_taken = b; flush = f; stall = s; branch_target = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        check({tag, "_instr"}, if_id_instr, 32'h0);
        check({tag, "_ipc"}, if_id_pc, 32'h0);
        check({tag, "_cnt"}, fetch_count, 32'h0);
        check({tag, "_mis"}, {31'b0, misalign_err}, 32'h0);
    endtask

    initial begin
        st_t sat;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b1;
        // sequential fetch after reset release
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check("seq_ipc", if_id_pc, 32'(4 * i));
            check("seq_instr", if_id_instr, 32'hA5A5_0000 | 32'(4 * i));
        end
        check("seq_cnt", fetch_count, 32'd3);
        cyc(0, 0, 0, 0);
        // stall at pc 0x10
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            check("stall_addr", imem_addr, 32'h10);
            check("stall_ipc", if_id_pc, 32'h0C);
            check("stall_instr", if_id_instr, 32'hA5A5_000C);
            check("stall_cnt", fetch_count, 32'd4);
        end
        cyc(0, 0, 0, 0);
        check("unstall_ipc", if_id_pc, 32'h10);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("pre_branch_addr", imem_addr, 32'h20);
        cyc(1, 0, 1, 32'h40);
        check("bvs_addr", imem_addr, 32'h40);
        check("bvs_valid", {31'b0, if_id_valid}, 32'h0);
        check("bvs_instr", if_id_instr, 32'h0);
        cyc(0, 0, 0, 0);
        check("bvs_ipc", if_id_pc, 32'h40);
        // flush then misaligned redirect
        cyc(1, 0, 0, 32'h8);
        cyc(0, 1, 0, 0);
        check("flush_addr", imem_addr, 32'h0C);
        check("flush_valid", {31'b0, if_id_valid}, 32'h0);
        cyc(1, 0, 0, 32'h43);
        check("mis_addr", imem_addr, 32'h40);
        check("mis_err", {31'b0, misalign_err}, 32'h1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 32'h100);
        check("mis_sticky", {31'b0, misalign_err}, 32'h1);
        // wrap
        cyc(1, 0, 0, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        check("wrap_ipc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_ipc4", if_id_pc_plus4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        // async reset while stalled at 0x30
        cyc(1, 0, 0, 32'h30);
        cyc(0, 0, 1, 0);
        stall = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset_vals("async");
        @(negedge clk);
        rst = 1'b1; stall = 1'b0;
        // model pin: the counter saturates
        sat = reset_st();
        sat.cnt = 32'hFFFF_FFFF;
        sat = step(sat, 0, 0, 0, 0);
        check("model_sat", sat.cnt, 32'hFFFF_FFFF);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 249) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, t);
        end
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the five-stage Harvard pipeline, directly upstream of decode inside top. It owns the program counter and drives a combinational-read instruction memory port. It also owns the IF/ID pipeline register. It honours stall, flush and branch-redirect requests from the later stages, and keeps a saturating fetch counter for the simulation benches.

Parameters:
PC_WIDTH, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on squash or reset (sll $0,$0,0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  squash IF/ID contents (e.g. jump resolved in ID)
branch_taken  in  1  redirect PC to branch_target
branch_target  in  PC_WIDTH  redirect address
imem_addr  out  PC_WIDTH  instruction memory address, equals current PC
imem_rdata  in  32  instruction memory data, combinational from imem_addr
if_id_instr  out  32  latched instruction
if_id_pc  out  PC_WIDTH  PC of latched instruction
if_id_pc_plus4  out  PC_WIDTH  if_id_pc + 4
if_id_valid  out  1  1 = real instruction, 0 = bubble
fetch_count  out  32  number of valid instructions latched, saturating
misalign_err  out  1  sticky: redirect target had bits[1:0] != 0

Behaviour:
- Reset (rst=0, async, regardless of clk):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0
  - if_id_valid=0, fetch_count=0, misalign_err=0
- Reset release is sampled synchronously. The first rising edge with rst=1 performs a normal fetch.
- imem_addr = pc, purely combinational. imem_rdata is used in the same cycle. Fetch-to-IF/ID latency is 1 cycle.
- Each rising edge applies exactly one case, in this priority order:
  1. branch_taken=1: pc <= {branch_target[PC_WIDTH-1:2],2'b00}; IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc fields keep previous values). Overrides stall and flush.
  2. flush=1 and stall=1: pc holds; IF/ID <= bubble.
  3. flush=1: pc <= pc+4; IF/ID <= bubble.
  4. stall=1: pc and all IF/ID fields hold, including valid.
  5. Normal: pc <= pc+4; if_id_instr <= imem_rdata; if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
- Arithmetic: pc+4 is modulo 2^PC_WIDTH, so 32'hFFFF_FFFC wraps to 0. There is no error on wrap.
- misalign_err:
  - set on any edge with branch_taken=1 and branch_target[1:0]!=0
  - remains 1 until reset
  - the redirect still proceeds to the forced-aligned address
- fetch_count:
  - increments by 1 on each edge in the normal case only
  - saturates at 32'hFFFF_FFFF
  - never decrements
- A reset asserted mid-stall or mid-redirect discards all pending state immediately. There is no pending-request memory across reset.
- No X on any output after the first reset assertion.

Test Plan:
- Reset/sequential:
  - Stimulus: rst=0 for 2 cycles, then rst=1; imem returns addr^32'hA5A5_0000.
  - Required during reset: imem_addr=0, if_id_valid=0, if_id_instr=0.
  - Required after edges 1/2/3: if_id_pc = 0/4/8, if_id_instr = A5A5_0000/A5A5_0004/A5A5_0008, fetch_count=3.
- Stall:
  - Stimulus: stall=1 for 3 edges at pc=0x10.
  - Required: imem_addr stays 0x10; IF/ID holds the instruction from 0x0C; fetch_count unchanged.
  - Required after release: next edge latches 0x10.
- Branch vs stall:
  - Stimulus: branch_taken=1, stall=1, branch_target=0x40 at pc=0x20.
  - Required next cycle: imem_addr=0x40, if_id_valid=0, if_id_instr=NOP.
  - Required on the following edge: if_id_pc=0x40.
- Flush and misalignment:
  - Stimulus: flush=1 alone at pc=0x8; then branch_target=0x43 with branch_taken=1.
  - Required: flush gives a bubble with pc becoming 0xC; the redirect sets pc=0x40 and misalign_err=1, which stays 1 until rst=0.
- Wrap:
  - Stimulus: branch to 0xFFFF_FFFC, then a normal edge.
  - Required: if_id_pc=0xFFFF_FFFC, if_id_pc_plus4=0, next imem_addr=0.
- Async reset mid-operation:
  - Stimulus: drop rst between clock edges while stalled at pc=0x30.
  - Required: all outputs reach reset values before the next rising edge; fetch_count=0.
